// File: rtl/sat_monitor.sv
// Full-scale clip monitor: counts +FS/-FS codes per window of valid samples and reports them
// through a valid/ack handshake. Define SAT_MONITOR_RUNLEN_EN to build longest-run tracking.
module sat_monitor #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned CWIDTH = 16,
  parameter int unsigned WWIDTH = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic [DWIDTH-1:0] din,
  input  logic [WWIDTH-1:0] window,
  input  logic              clear,
  output logic              sat_now,
  output logic [CWIDTH-1:0] pos_count,
  output logic [CWIDTH-1:0] neg_count,
  output logic [CWIDTH-1:0] run_max,
  output logic              rpt_valid,
  input  logic              rpt_ack,
  output logic              overrun
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [DWIDTH-1:0] PosFs = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] NegFs = {1'b1, {(DWIDTH-1){1'b0}}};

  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v, input logic en);
    if (en && (v != {CWIDTH{1'b1}})) begin
      return v + CWIDTH'(1);
    end
    return v;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [WWIDTH-1:0] win_len_q, win_len_d;
  logic [WWIDTH-1:0] samp_cnt_q, samp_cnt_d;
  logic [CWIDTH-1:0] pos_acc_q, pos_acc_d;
  logic [CWIDTH-1:0] neg_acc_q, neg_acc_d;
  logic [CWIDTH-1:0] pos_count_q, pos_count_d;
  logic [CWIDTH-1:0] neg_count_q, neg_count_d;
  logic              rpt_valid_q, rpt_valid_d;
  logic              overrun_q, overrun_d;
  logic              sat_now_q, sat_now_d;

  logic              is_pos, is_neg;
  logic              acc_zero, step, win_end, rpt_load;
  logic [WWIDTH-1:0] win_len_in, samp_cnt_inc;
  logic [CWIDTH-1:0] pos_acc_inc, neg_acc_inc;

  assign is_pos       = (din == PosFs);
  assign is_neg       = (din == NegFs);
  assign win_len_in   = (window == '0) ? WWIDTH'(1) : window;
  assign samp_cnt_inc = samp_cnt_q + WWIDTH'(1);
  assign pos_acc_inc  = sat_inc(pos_acc_q, is_pos);
  assign neg_acc_inc  = sat_inc(neg_acc_q, is_neg);

  assign acc_zero = clear || (state_q == StIdle);
  assign step     = !clear && (state_q == StRun) && din_valid;
  assign win_end  = step && (samp_cnt_inc == win_len_q);
  // A pending report can be replaced only when it is being acknowledged this cycle.
  assign rpt_load = win_end && (!rpt_valid_q || rpt_ack);

  always_comb begin
    state_d     = state_q;
    win_len_d   = win_len_q;
    samp_cnt_d  = samp_cnt_q;
    pos_acc_d   = pos_acc_q;
    neg_acc_d   = neg_acc_q;
    pos_count_d = pos_count_q;
    neg_count_d = neg_count_q;
    rpt_valid_d = rpt_valid_q;
    overrun_d   = overrun_q;
    sat_now_d   = 1'b0;

    if (clear) begin
      state_d     = StIdle;
      samp_cnt_d  = '0;
      pos_acc_d   = '0;
      neg_acc_d   = '0;
      pos_count_d = '0;
      neg_count_d = '0;
      rpt_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else if (state_q == StIdle) begin
      state_d    = StRun;
      win_len_d  = win_len_in;
      samp_cnt_d = '0;
      pos_acc_d  = '0;
      neg_acc_d  = '0;
    end else begin
      if (rpt_valid_q && rpt_ack) begin
        rpt_valid_d = 1'b0;
      end
      if (din_valid) begin
        sat_now_d  = is_pos || is_neg;
        samp_cnt_d = samp_cnt_inc;
        pos_acc_d  = pos_acc_inc;
        neg_acc_d  = neg_acc_inc;
        if (win_end) begin
          if (rpt_load) begin
            pos_count_d = pos_acc_inc;
            neg_count_d = neg_acc_inc;
            rpt_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          samp_cnt_d = '0;
          pos_acc_d  = '0;
          neg_acc_d  = '0;
          win_len_d  = win_len_in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      win_len_q   <= '0;
      samp_cnt_q  <= '0;
      pos_acc_q   <= '0;
      neg_acc_q   <= '0;
      pos_count_q <= '0;
      neg_count_q <= '0;
      rpt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sat_now_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      samp_cnt_q  <= samp_cnt_d;
      pos_acc_q   <= pos_acc_d;
      neg_acc_q   <= neg_acc_d;
      pos_count_q <= pos_count_d;
      neg_count_q <= neg_count_d;
      rpt_valid_q <= rpt_valid_d;
      overrun_q   <= overrun_d;
      sat_now_q   <= sat_now_d;
    end
  end

  assign sat_now   = sat_now_q;
  assign pos_count = pos_count_q;
  assign neg_count = neg_count_q;
  assign rpt_valid = rpt_valid_q;
  assign overrun   = overrun_q;

`ifdef SAT_MONITOR_RUNLEN_EN
  logic [CWIDTH-1:0] run_cur_q, run_cur_d;
  logic              run_neg_q, run_neg_d;
  logic [CWIDTH-1:0] run_max_acc_q, run_max_acc_d;
  logic [CWIDTH-1:0] run_max_q, run_max_d;
  logic [CWIDTH-1:0] run_next, run_max_next;

  always_comb begin
    run_cur_d     = run_cur_q;
    run_neg_d     = run_neg_q;
    run_max_acc_d = run_max_acc_q;
    run_max_d     = run_max_q;
    run_next      = run_cur_q;
    // Invalid cycles leave the run untouched; only an unsaturated valid sample breaks it.
    if (is_pos || is_neg) begin
      if ((run_cur_q != '0) && (run_neg_q == is_neg)) begin
        run_next = sat_inc(run_cur_q, 1'b1);
      end else begin
        run_next = CWIDTH'(1);
      end
    end else begin
      run_next = '0;
    end
    run_max_next = (run_next > run_max_acc_q) ? run_next : run_max_acc_q;

    if (acc_zero) begin
      run_cur_d     = '0;
      run_neg_d     = 1'b0;
      run_max_acc_d = '0;
      if (clear) begin
        run_max_d = '0;
      end
    end else if (step) begin
      if (win_end) begin
        run_cur_d     = '0;
        run_neg_d     = 1'b0;
        run_max_acc_d = '0;
        if (rpt_load) begin
          run_max_d = run_max_next;
        end
      end else begin
        run_cur_d     = run_next;
        run_neg_d     = is_neg;
        run_max_acc_d = run_max_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cur_q     <= '0;
      run_neg_q     <= 1'b0;
      run_max_acc_q <= '0;
      run_max_q     <= '0;
    end else begin
      run_cur_q     <= run_cur_d;
      run_neg_q     <= run_neg_d;
      run_max_acc_q <= run_max_acc_d;
      run_max_q     <= run_max_d;
    end
  end

  assign run_max = run_max_q;
`else
  assign run_max = '0;
`endif

endmodule

// File: tb/tb_sat_monitor.sv
// Directed bench for sat_monitor (DWIDTH=8, CWIDTH=4) with a cycle-by-cycle reference model.
module tb_sat_monitor;

  localparam int CMAX = 15;

  logic       clk;
  logic       rst_n;
  logic       din_valid;
  logic [7:0] din;
  logic [7:0] window;
  logic       clear;
  logic       sat_now;
  logic [3:0] pos_count;
  logic [3:0] neg_count;
  logic [3:0] run_max;
  logic       rpt_valid;
  logic       rpt_ack;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  sat_monitor #(
    .DWIDTH(8),
    .CWIDTH(4),
    .WWIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_valid(din_valid),
    .din      (din),
    .window   (window),
    .clear    (clear),
    .sat_now  (sat_now),
    .pos_count(pos_count),
    .neg_count(neg_count),
    .run_max  (run_max),
    .rpt_valid(rpt_valid),
    .rpt_ack  (rpt_ack),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: unbounded integer counts, clamped only when a report is taken.
  bit m_idle, m_rv, m_ov, m_sat, m_runneg;
  int m_win, m_cnt, m_pos, m_neg, m_run, m_rmax;
  int r_pos, r_neg, r_run;

  function automatic int clamp(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic m_zero_acc();
    m_cnt = 0; m_pos = 0; m_neg = 0; m_run = 0; m_rmax = 0; m_runneg = 0;
  endtask

  task automatic m_reset();
    m_zero_acc();
    m_idle = 1; m_rv = 0; m_ov = 0; m_sat = 0;
    r_pos = 0; r_neg = 0; r_run = 0;
  endtask

  task automatic m_step();
    bit fp, fn;
    if (!rst_n || clear) begin
      m_reset();
    end else if (m_idle) begin
      m_idle = 0;
      m_win  = (window == 0) ? 1 : int'(window);
      m_zero_acc();
      m_sat = 0;
    end else begin
      fp = din_valid && (din == 8'h7F);
      fn = din_valid && (din == 8'h80);
      m_sat = fp || fn;
      if (m_rv && rpt_ack) m_rv = 0;
      if (din_valid) begin
        m_cnt++;
        if (fp) m_pos++;
        if (fn) m_neg++;
        if (fp || fn) begin
          if (m_run > 0 && m_runneg == fn) m_run++;
          else m_run = 1;
          m_runneg = fn;
        end else begin
          m_run = 0;
        end
        if (m_run > m_rmax) m_rmax = m_run;
        if (m_cnt == m_win) begin
          if (!m_rv) begin
            r_pos = clamp(m_pos);
            r_neg = clamp(m_neg);
            r_run = clamp(m_rmax);
            m_rv  = 1;
          end else begin
            m_ov = 1;
          end
          m_zero_acc();
          m_win = (window == 0) ? 1 : int'(window);
        end
      end
    end
  endtask

  function automatic int exp_run(input int v);
`ifdef SAT_MONITOR_RUNLEN_EN
    return v;
`else
    return 0;
`endif
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      m_step();
      #1;
      check("sat_now", 32'(sat_now), 32'(m_sat));
      check("pos_count", 32'(pos_count), 32'(r_pos));
      check("neg_count", 32'(neg_count), 32'(r_neg));
      check("run_max", 32'(run_max), 32'(exp_run(r_run)));
      check("rpt_valid", 32'(rpt_valid), 32'(m_rv));
      check("overrun", 32'(overrun), 32'(m_ov));
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic a);
    @(negedge clk);
    din_valid = v;
    din       = d;
    rpt_ack   = a;
  endtask

  // The cycle after clear is the IDLE cycle; a valid full-scale sample there must be ignored.
  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; din_valid = 1'b0; rpt_ack = 1'b0;
    @(negedge clk);
    clear = 1'b0; din_valid = 1'b1; din = 8'h7F;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rv"}, 32'(rpt_valid), 0);
    check({tag, "_pos"}, 32'(pos_count), 0);
    check({tag, "_neg"}, 32'(neg_count), 0);
    check({tag, "_run"}, 32'(run_max), 0);
    check({tag, "_ov"}, 32'(overrun), 0);
    check({tag, "_sat"}, 32'(sat_now), 0);
  endtask

  logic [7:0] s1 [8] = '{8'h7F, 8'h7F, 8'h80, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h80};

  initial begin
    rst_n = 1'b0; clear = 1'b0; din_valid = 1'b0; din = 8'h00; window = 8'd8; rpt_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Basic window of 8
    foreach (s1[i]) drive(1'b1, s1[i], 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("w8_rv", 32'(rpt_valid), 1);
    check("w8_pos", 32'(pos_count), 5);
    check("w8_neg", 32'(neg_count), 2);
    check("w8_run", 32'(run_max), 32'(exp_run(3)));
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    check("w8_ack_drop", 32'(rpt_valid), 0);

    // Overrun: two windows with no ack
    window = 8'd4;
    do_clear();
    check_zero("clr1");
    drive(1'b1, 8'h7F, 1'b0);
    repeat (3) drive(1'b1, 8'h00, 1'b0);
    repeat (4) drive(1'b1, 8'h80, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("ovr_rv", 32'(rpt_valid), 1);
    check("ovr_pos", 32'(pos_count), 1);
    check("ovr_neg", 32'(neg_count), 0);
    check("ovr_flag", 32'(overrun), 1);
    drive(1'b0, 8'h00, 1'b1);

    // Ack coincident with the next window end
    do_clear();
    check("clr2_ov", 32'(overrun), 0);
    repeat (2) drive(1'b1, 8'h7F, 1'b0);
    repeat (2) drive(1'b1, 8'h00, 1'b0);
    repeat (3) drive(1'b1, 8'h80, 1'b0);
    drive(1'b1, 8'h80, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    check("coin_rv", 32'(rpt_valid), 1);
    check("coin_pos", 32'(pos_count), 0);
    check("coin_neg", 32'(neg_count), 4);
    check("coin_run", 32'(run_max), 32'(exp_run(4)));
    check("coin_ov", 32'(overrun), 0);
    drive(1'b0, 8'h00, 1'b1);

    // Counter saturation
    window = 8'd32;
    do_clear();
    repeat (32) drive(1'b1, 8'h7F, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("sat_rv", 32'(rpt_valid), 1);
    check("sat_pos", 32'(pos_count), 15);
    check("sat_neg", 32'(neg_count), 0);
    check("sat_run", 32'(run_max), 32'(exp_run(15)));
    drive(1'b0, 8'h00, 1'b1);

    // Window change mid-window takes effect next window
    window = 8'd8;
    do_clear();
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h7F, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    window = 8'd3;
    drive(1'b1, 8'h80, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h7F, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("wchg_early_rv", 32'(rpt_valid), 0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("wchg8_rv", 32'(rpt_valid), 1);
    check("wchg8_pos", 32'(pos_count), 2);
    check("wchg8_neg", 32'(neg_count), 1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h80, 1'b0);
    drive(1'b1, 8'h80, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("wchg3_early_rv", 32'(rpt_valid), 0);
    drive(1'b1, 8'h80, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("wchg3_rv", 32'(rpt_valid), 1);
    check("wchg3_neg", 32'(neg_count), 3);
    drive(1'b0, 8'h00, 1'b1);

    // window=0 behaves as 1
    window = 8'd0;
    do_clear();
    drive(1'b1, 8'h7F, 1'b1);
    drive(1'b1, 8'h80, 1'b1);
    check("w0a_rv", 32'(rpt_valid), 1);
    check("w0a_pos", 32'(pos_count), 1);
    drive(1'b1, 8'h00, 1'b1);
    check("w0b_pos", 32'(pos_count), 0);
    check("w0b_neg", 32'(neg_count), 1);
    drive(1'b0, 8'h00, 1'b1);
    check("w0c_neg", 32'(neg_count), 0);
    check("w0c_rv", 32'(rpt_valid), 1);
    drive(1'b0, 8'h00, 1'b0);
    check("w0d_rv", 32'(rpt_valid), 0);

    // Clear mid-window loses the partial window
    window = 8'd8;
    do_clear();
    repeat (3) drive(1'b1, 8'h7F, 1'b0);
    do_clear();
    check_zero("clr_mid");
    repeat (7) drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h80, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("clrw_rv", 32'(rpt_valid), 1);
    check("clrw_pos", 32'(pos_count), 0);
    check("clrw_neg", 32'(neg_count), 1);

    // Asynchronous reset mid-handshake
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) drive(1'b1, 8'h7F, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("arst_rv", 32'(rpt_valid), 1);
    check("arst_pos", 32'(pos_count), 8);
    check("arst_run", 32'(run_max), 32'(exp_run(8)));
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
